// File: rtl/wakeup_delay_pipeline.sv
// Per-port delay line between select and wakeup: an op selected with latency code c wakes c+1 cycles later.
// Release is registered one cycle after select; stall holds all state and masks wakeup/release/collision.
// Build option `WAKEUP_PERF_COUNT_EN adds saturating wakeup/collision counters.
module wakeup_delay_pipeline #(
   parameter int ISSUE_WIDTH    = 4,
   parameter int IQ_ENTRY_NUM   = 16,
   parameter int IQ_INDEX_WIDTH = 4,
   parameter int MAX_LAT        = 4,
   parameter int LAT_WIDTH      = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   stall,
   input  logic [ISSUE_WIDTH-1:0]                 selected,
   input  logic [ISSUE_WIDTH*IQ_INDEX_WIDTH-1:0]  selectedPtr,
   input  logic [ISSUE_WIDTH*IQ_ENTRY_NUM-1:0]    selectedVector,
   input  logic [ISSUE_WIDTH*LAT_WIDTH-1:0]       selectedLat,
   input  logic                                   flush,
   input  logic [IQ_ENTRY_NUM-1:0]                flushMask,
   output logic [ISSUE_WIDTH-1:0]                 wakeup,
   output logic [ISSUE_WIDTH*IQ_INDEX_WIDTH-1:0]  wakeupPtr,
   output logic [ISSUE_WIDTH*IQ_ENTRY_NUM-1:0]    wakeupVector,
   output logic [ISSUE_WIDTH-1:0]                 releaseEntry,
   output logic [ISSUE_WIDTH*IQ_INDEX_WIDTH-1:0]  releasePtr,
   output logic [ISSUE_WIDTH-1:0]                 collision
`ifdef WAKEUP_PERF_COUNT_EN
   ,
   output logic [31:0]                            perfWakeupCount,
   output logic [31:0]                            perfCollisionCount
`endif
);

   typedef struct packed {
      logic                      vld;
      logic [IQ_INDEX_WIDTH-1:0] ptr;
      logic [IQ_ENTRY_NUM-1:0]   vec;
   } stage_t;

   stage_t                               st     [ISSUE_WIDTH][MAX_LAT];
   stage_t                               st_nxt [ISSUE_WIDTH][MAX_LAT];
   logic [ISSUE_WIDTH-1:0]               col_nxt;
   logic [ISSUE_WIDTH-1:0]               col_q;
   logic [ISSUE_WIDTH-1:0]               rel_vld;
   logic [ISSUE_WIDTH*IQ_INDEX_WIDTH-1:0] rel_ptr;

   // Latencies beyond the delay-line depth land in the last stage.
   function automatic int lat_idx(input logic [LAT_WIDTH-1:0] code);
      return (int'(code) >= MAX_LAT) ? MAX_LAT - 1 : int'(code);
   endfunction

   always_comb begin
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
         col_nxt[p] = 1'b0;
         for (int k = 0; k < MAX_LAT; k++) begin
            st_nxt[p][k] = stall ? st[p][k] : '0;
         end
         if (!stall) begin
            for (int k = 0; k < MAX_LAT - 1; k++) begin
               st_nxt[p][k] = st[p][k+1];
            end
            // The older op already travelling through the target stage wins.
            if (selected[p]) begin
               if (st_nxt[p][lat_idx(selectedLat[p*LAT_WIDTH +: LAT_WIDTH])].vld) begin
                  col_nxt[p] = 1'b1;
               end else begin
                  st_nxt[p][lat_idx(selectedLat[p*LAT_WIDTH +: LAT_WIDTH])] =
                     '{1'b1, selectedPtr[p*IQ_INDEX_WIDTH +: IQ_INDEX_WIDTH],
                       selectedVector[p*IQ_ENTRY_NUM +: IQ_ENTRY_NUM]};
               end
            end
         end
         for (int k = 0; k < MAX_LAT; k++) begin
            if (flush && |(st_nxt[p][k].vec & flushMask)) begin
               st_nxt[p][k].vld = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int k = 0; k < MAX_LAT; k++) begin
               st[p][k] <= '0;
            end
         end
         col_q   <= '0;
         rel_vld <= '0;
         rel_ptr <= '0;
      end else begin
         for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int k = 0; k < MAX_LAT; k++) begin
               st[p][k] <= st_nxt[p][k];
            end
         end
         if (!stall) begin
            col_q   <= col_nxt;
            rel_vld <= selected;
            rel_ptr <= selectedPtr;
         end
      end
   end

   for (genvar p = 0; p < ISSUE_WIDTH; p++) begin : g_out
      assign wakeup[p]                                          = st[p][0].vld & ~stall;
      assign wakeupPtr[p*IQ_INDEX_WIDTH +: IQ_INDEX_WIDTH]      = st[p][0].ptr;
      assign wakeupVector[p*IQ_ENTRY_NUM +: IQ_ENTRY_NUM]       = st[p][0].vec;
   end

   assign releaseEntry = rel_vld & {ISSUE_WIDTH{~stall}};
   assign releasePtr   = rel_ptr;
   assign collision    = col_q & {ISSUE_WIDTH{~stall}};

`ifdef WAKEUP_PERF_COUNT_EN
   logic [32:0] wk_sum;
   logic [32:0] col_sum;

   assign wk_sum  = {1'b0, perfWakeupCount}    + 33'($countones(wakeup));
   assign col_sum = {1'b0, perfCollisionCount} + 33'($countones(collision));

   always_ff @(posedge clk) begin
      if (rst) begin
         perfWakeupCount    <= '0;
         perfCollisionCount <= '0;
      end else if (!stall) begin
         perfWakeupCount    <= wk_sum[32]  ? '1 : wk_sum[31:0];
         perfCollisionCount <= col_sum[32] ? '1 : col_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_wakeup_delay_pipeline.sv
// Self-checking bench for wakeup_delay_pipeline: vector table plus hand-written corner sequences,
// all checked through a scoreboard of expected wakeup/release/collision events keyed by cycle.
`timescale 1ns/1ps
module tb_wakeup_delay_pipeline;
   localparam int P  = 4;
   localparam int N  = 16;
   localparam int W  = 4;
   localparam int LW = 2;
   localparam int K_WK  = 0;
   localparam int K_REL = 1;
   localparam int K_COL = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall;
   logic [P-1:0]    selected;
   logic [P*W-1:0]  selectedPtr;
   logic [P*N-1:0]  selectedVector;
   logic [P*LW-1:0] selectedLat;
   logic            flush;
   logic [N-1:0]    flushMask;
   logic [P-1:0]    wakeup;
   logic [P*W-1:0]  wakeupPtr;
   logic [P*N-1:0]  wakeupVector;
   logic [P-1:0]    releaseEntry;
   logic [P*W-1:0]  releasePtr;
   logic [P-1:0]    collision;
`ifdef WAKEUP_PERF_COUNT_EN
   logic [31:0]     perfWakeupCount;
   logic [31:0]     perfCollisionCount;
`endif

   wakeup_delay_pipeline dut (
      .clk(clk), .rst(rst), .stall(stall),
      .selected(selected), .selectedPtr(selectedPtr),
      .selectedVector(selectedVector), .selectedLat(selectedLat),
      .flush(flush), .flushMask(flushMask),
      .wakeup(wakeup), .wakeupPtr(wakeupPtr), .wakeupVector(wakeupVector),
      .releaseEntry(releaseEntry), .releasePtr(releasePtr),
      .collision(collision)
`ifdef WAKEUP_PERF_COUNT_EN
      , .perfWakeupCount(perfWakeupCount), .perfCollisionCount(perfCollisionCount)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int kind; int cyc; int port; int ptr; } ev_t;
   typedef struct { int port; int ptr; int code; int lat; } vec_t;

   ev_t  ev_q[$];
   vec_t tbl[10];
   int   cyc;
   int   checks;
   int   errors;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_in();
      rst = 1'b0; stall = 1'b0; flush = 1'b0; flushMask = '0;
      selected = '0; selectedPtr = '0; selectedVector = '0; selectedLat = '0;
   endtask

   task automatic sel(input int p, input int ptr, input int code);
      selected[p]              = 1'b1;
      selectedPtr[p*W +: W]    = W'(ptr);
      selectedVector[p*N +: N] = N'(1) << ptr;
      selectedLat[p*LW +: LW]  = LW'(code);
   endtask

   task automatic push(input int kind, input int at, input int p, input int ptr);
      ev_q.push_back('{kind, at, p, ptr});
   endtask

   task automatic check_cycle();
      logic [P-1:0] ew, er, ec;
      int           ewp[P];
      int           erp[P];
      ev_t          keep[$];
      ew = '0; er = '0; ec = '0;
      foreach (ev_q[i]) begin
         if (ev_q[i].cyc == cyc) begin
            case (ev_q[i].kind)
               K_WK:    begin ew[ev_q[i].port] = 1'b1; ewp[ev_q[i].port] = ev_q[i].ptr; end
               K_REL:   begin er[ev_q[i].port] = 1'b1; erp[ev_q[i].port] = ev_q[i].ptr; end
               default: ec[ev_q[i].port] = 1'b1;
            endcase
         end else begin
            keep.push_back(ev_q[i]);
         end
      end
      ev_q = keep;
      cmp("wakeup", 64'(wakeup), 64'(ew));
      cmp("releaseEntry", 64'(releaseEntry), 64'(er));
      cmp("collision", 64'(collision), 64'(ec));
      for (int p = 0; p < P; p++) begin
         if (ew[p]) begin
            cmp("wakeupPtr", 64'(wakeupPtr[p*W +: W]), 64'(ewp[p]));
            cmp("wakeupVector", 64'(wakeupVector[p*N +: N]), 64'(1) << ewp[p]);
         end
         if (er[p]) cmp("releasePtr", 64'(releasePtr[p*W +: W]), 64'(erp[p]));
      end
   endtask

   // Inputs for the current cycle are already driven; check outputs, then advance one edge.
   task automatic step();
      #1;
      check_cycle();
      @(posedge clk);
      #1;
      cyc++;
      clear_in();
   endtask

   initial begin
      int b;
      checks = 0; errors = 0; cyc = 0;
      tbl[0] = '{0,  5, 0, 1};
      tbl[1] = '{1,  3, 3, 4};
      tbl[2] = '{2, 15, 1, 2};
      tbl[3] = '{3,  0, 2, 3};
      tbl[4] = '{0,  8, 3, 4};
      tbl[5] = '{0,  9, 0, 1};
      tbl[6] = '{1, 12, 2, 3};
      tbl[7] = '{2,  1, 0, 1};
      tbl[8] = '{3, 10, 1, 2};
      tbl[9] = '{1,  3, 1, 2};

      clear_in();
      rst = 1'b1;
      @(posedge clk);
      #1;
      cmp("rst_wakeupPtr", 64'(wakeupPtr), 64'd0);
      cmp("rst_wakeupVector", wakeupVector, 64'd0);
      cmp("rst_releasePtr", 64'(releasePtr), 64'd0);
      rst = 1'b1;
      step();

      // Non-colliding selects spread over ports and latency codes.
      foreach (tbl[i]) begin
         sel(tbl[i].port, tbl[i].ptr, tbl[i].code);
         push(K_WK, cyc + tbl[i].lat, tbl[i].port, tbl[i].ptr);
         push(K_REL, cyc + 1, tbl[i].port, tbl[i].ptr);
         step();
      end
      repeat (6) step();

      // Collision: ptr7 targets the stage ptr2 is shifting into.
      b = cyc;
      sel(0, 2, 2); push(K_WK, b + 3, 0, 2); push(K_REL, b + 1, 0, 2); step();
      sel(0, 7, 1); push(K_REL, b + 2, 0, 7); push(K_COL, b + 2, 0, 0); step();
      repeat (5) step();

      // Stall for two cycles delays wakeup and holds the release.
      b = cyc;
      sel(0, 9, 3); push(K_WK, b + 6, 0, 9); push(K_REL, b + 3, 0, 9); step();
      stall = 1'b1; step();
      stall = 1'b1; step();
      repeat (6) step();

      // Flush kills an in-flight op and a same-cycle insert, not their releases.
      b = cyc;
      sel(0, 4, 2); sel(1, 6, 2);
      push(K_REL, b + 1, 0, 4); push(K_REL, b + 1, 1, 6); push(K_WK, b + 3, 1, 6);
      step();
      flush = 1'b1; flushMask = (N'(1) << 4) | (N'(1) << 11);
      sel(2, 11, 1); push(K_REL, b + 2, 2, 11);
      step();
      repeat (5) step();

      // Flush during stall applies to held state.
      b = cyc;
      sel(3, 14, 1); push(K_REL, b + 2, 3, 14); step();
      stall = 1'b1; flush = 1'b1; flushMask = N'(1) << 14; step();
      repeat (5) step();

      // Reset mid-flight drops the pending wakeup.
      b = cyc;
      sel(0, 13, 3); push(K_REL, b + 1, 0, 13); step();
      step();
      rst = 1'b1; step();
      cmp("midrst_wakeupPtr", 64'(wakeupPtr), 64'd0);
      cmp("midrst_releasePtr", 64'(releasePtr), 64'd0);
      repeat (5) step();

`ifdef WAKEUP_PERF_COUNT_EN
      rst = 1'b1; step();
      repeat (10) begin
         for (int p = 0; p < P; p++) begin
            sel(p, p + 1, 0);
            push(K_WK, cyc + 1, p, p + 1);
            push(K_REL, cyc + 1, p, p + 1);
         end
         step();
      end
      repeat (2) step();
      cmp("perfWakeupCount", 64'(perfWakeupCount), 64'd40);
      cmp("perfCollisionCount", 64'(perfCollisionCount), 64'd0);
`endif

      cmp("leftover_events", 64'(ev_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
